// File: rtl/pcie_ss_flr_tracker.sv
// Queues sideband FLR events, broadcasts each to NUM_CH channels, and returns one completion per FLR.
// Pop happens 1 edge after write; events carry no backpressure (duplicates merge, overflow drops); completions wait on i_rsp_ready.
module pcie_ss_flr_tracker #(
    parameter  int NUM_CH         = 4,
    parameter  int DEPTH          = 8,
    parameter  int PF_WIDTH       = 3,
    parameter  int VF_WIDTH       = 11,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int FUNC_W         = 6 + VF_WIDTH + PF_WIDTH,
    localparam int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flr_valid,
    input  logic [FUNC_W-1:0] i_flr_func,
    input  logic [NUM_CH-1:0] i_ch_mask,
    output logic [NUM_CH-1:0] o_ch_flr_valid,
    output logic [FUNC_W-1:0] o_ch_flr_func,
    input  logic [NUM_CH-1:0] i_ch_flr_ack,
    output logic              o_rsp_valid,
    output logic [FUNC_W-1:0] o_rsp_func,
    output logic              o_rsp_timeout,
    output logic [NUM_CH-1:0] o_rsp_missing,
    input  logic              i_rsp_ready,
    output logic [CNT_W-1:0]  o_pending_cnt,
    output logic              o_busy,
    output logic              o_dup_pulse,
    output logic              o_drop_pulse,
    output logic [7:0]        o_drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;

    state_t            state, state_nxt;
    logic [FUNC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [FUNC_W-1:0] active_func, func_nxt;
    logic [NUM_CH-1:0] pend, pend_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic              rsp_timeout, to_nxt;
    logic [NUM_CH-1:0] rsp_missing, miss_nxt;
    logic [DEPTH-1:0]  ent_hit;
    logic              hit, full, wr, drop, pop;
    logic              dup_q, drop_q;
    logic [7:0]        drop_cnt;

    // An entry is live when its distance from the head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        logic [PTR_W-1:0] off;
        assign off        = PTR_W'(g) - rd_ptr;
        assign ent_hit[g] = ({1'b0, off} < cnt) && (mem[g] == i_flr_func);
    end

    assign hit  = (|ent_hit) || ((state != IDLE) && (active_func == i_flr_func));
    assign full = (cnt == CNT_W'(DEPTH));
    assign wr   = i_flr_valid && !hit && !full;
    assign drop = i_flr_valid && !hit && full;
    assign pop  = (state == IDLE) && (cnt != '0);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= i_flr_func;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            dup_q    <= 1'b0;
            drop_q   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop)      cnt <= cnt + 1'b1;
            else if (!wr && pop) cnt <= cnt - 1'b1;
            dup_q  <= i_flr_valid && hit;
            drop_q <= drop;
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            active_func <= '0;
            pend        <= '0;
            timer       <= '0;
            rsp_timeout <= 1'b0;
            rsp_missing <= '0;
        end else begin
            state       <= state_nxt;
            active_func <= func_nxt;
            pend        <= pend_nxt;
            timer       <= timer_nxt;
            rsp_timeout <= to_nxt;
            rsp_missing <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        func_nxt  = active_func;
        pend_nxt  = pend;
        timer_nxt = timer;
        to_nxt    = rsp_timeout;
        miss_nxt  = rsp_missing;
        case (state)
            IDLE: begin
                if (pop) begin
                    func_nxt  = mem[rd_ptr];
                    pend_nxt  = i_ch_mask;
                    timer_nxt = '0;
                    to_nxt    = 1'b0;
                    miss_nxt  = '0;
                    state_nxt = (i_ch_mask != '0) ? WAIT_ACK : RESP;
                end
            end
            WAIT_ACK: begin
                // A full ack set on the expiry edge still counts as a clean completion.
                pend_nxt = pend & ~i_ch_flr_ack;
                if (pend_nxt == '0) begin
                    state_nxt = RESP;
                end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = RESP;
                    to_nxt    = 1'b1;
                    miss_nxt  = pend_nxt;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_ch_flr_valid = (state == WAIT_ACK) ? pend : '0;
    assign o_ch_flr_func  = (state != IDLE) ? active_func : '0;
    assign o_rsp_valid    = (state == RESP);
    assign o_rsp_func     = (state != IDLE) ? active_func : '0;
    assign o_rsp_timeout  = (state == RESP) ? rsp_timeout : 1'b0;
    assign o_rsp_missing  = (state == RESP) ? rsp_missing : '0;
    assign o_pending_cnt  = cnt;
    assign o_busy         = (state != IDLE) || (cnt != '0);
    assign o_dup_pulse    = dup_q;
    assign o_drop_pulse   = drop_q;
    assign o_drop_cnt     = drop_cnt;
endmodule
